tcb_lib_processor2memory: RTL and testbench
===========================================

Name: tcb_lib_processor2memory

Overview:
- Parametrised TCB mode converter. Manager side is a processor-mode TCB, with data always LSB-aligned. Subordinate side is a memory-mode TCB, with data placed in lanes by address.
- Forwards requests, rotates write data and generates byte enables for the configured endianness.
- Tracks in-flight requests through a fixed-delay response pipeline so that read data can be realigned back to LSB.
- Sits between a CPU load/store unit and SRAM or peripheral interconnect.

Parameters:
- ABW, 32, address bus width.
- DBW, 32, data bus width; a power of two, 8..128.
- DLY, 1, subordinate read/response latency in cycles; range 1..4.
- ENDIAN, TCB_LITTLE, byte order; tcb_mode_endianness_t.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- man_vld  in  1  manager request valid
- man_rdy  out  1  manager request ready
- man_wen  in  1  write enable
- man_adr  in  ABW  byte address
- man_siz  in  3  transfer size; tcb_size_t encoding, 2^siz bytes
- man_wdt  in  DBW  write data, LSB-aligned
- man_rdt  out  DBW  read data, LSB-aligned
- man_err  out  1  response error
- man_uns  in  1  unsigned load; present only with the macro
- sub_vld  out  1  subordinate request valid
- sub_rdy  in  1  subordinate ready
- sub_wen  out  1  write enable
- sub_adr  out  ABW  address, passed through unchanged
- sub_ben  out  DBW/8  byte enables
- sub_wdt  out  DBW  write data, lane-aligned
- sub_rdt  in  DBW  read data, lane-aligned
- sub_err  in  1  subordinate error

Behaviour:
- Definitions:
  - BEN = DBW/8.
  - off = man_adr[log2(BEN)-1:0].
  - n = 2^man_siz.
  - A transfer occurs when man_vld && man_rdy.
- Illegal request: (off mod n) != 0, or n > BEN.
- Request path is combinational; it adds no latency.
- Legal request:
  - sub_vld = man_vld; man_rdy = sub_rdy.
  - sub_ben bits off..off+n-1 are set; all others are 0.
- Illegal request:
  - sub_vld = 0 and man_rdy = 1; the request is consumed locally and never reaches the subordinate.
- Write lane mapping:
  - Little-endian: lane off+i carries man_wdt byte i, for i in 0..n-1.
  - Big-endian: lane off+i carries man_wdt byte n-1-i.
  - Lanes outside the window carry don't-care data; the RTL drives 0.
- Response pipeline: DLY-stage shift register. Each stage holds {act, wen, off, siz, ill, uns}.
  - Stage 0 loads on every clk: act = transfer, with the request attributes.
  - Each later stage copies the previous one.
- Response timing: the response to a transfer in cycle t appears in cycle t+DLY, taken from the last stage.
  - When the last stage has act=0: man_rdt = 0 and man_err = 0.
  - Transfers back-to-back every cycle are supported; the response order equals the request order.
- Read realignment, applied when the last stage has act=1 and wen=0:
  - Little-endian: byte i = sub_rdt lane off+i.
  - Big-endian: byte i = lane off+n-1-i.
  - Bytes n..BEN-1 are zero-extended.
- Write responses: man_rdt = 0.
- Error:
  - man_err = ill | sub_err in the response cycle.
  - For ill = 1: man_rdt = 0 and sub_rdt is ignored.
- Reset (rst_n low, asynchronous): all pipeline stages are cleared to act=0. Consequently man_rdt = 0 and man_err = 0, while combinational outputs follow their inputs.
- Reset mid-operation: in-flight responses are discarded; no response appears after reset release.
- Sizes are fixed by the parameters; there are no runtime modes.

Optional Feature:
- Macro: TCB_LIB_P2M_SIGN_EXT_EN.
- Defined:
  - Port man_uns exists and is captured per transfer into the pipeline.
  - Read responses with uns=0 sign-extend bytes n..BEN-1 from bit 8n-1 of the realigned value.
  - Read responses with uns=1 zero-extend.
  - Write and error responses are unaffected.
- Undefined: man_uns is absent and all reads zero-extend.

Test Plan:
- DBW=32, LE, DLY=1. Write adr=0x6, siz=1, wdt=0x0000_BEEF.
  - Expect sub_ben=4'b1100 and sub_wdt=0xBEEF_0000.
  - Next cycle: man_err=0, man_rdt=0.
- DBW=32, BE. Read adr=0x4, siz=2, sub_rdt=0x1122_3344 returned after DLY.
  - Expect sub_ben=4'b1111 and man_rdt=0x4433_2211.
- DLY=3, LE. Four back-to-back reads at adr=0,1,2,3, siz=0, with sub_rdt constant 0xDDCC_BBAA.
  - Expect man_rdt = 0xAA, 0xBB, 0xCC, 0xDD on cycles t+3..t+6.
- Misaligned request: adr=0x3, siz=2.
  - Expect sub_vld=0 and man_rdy=1 in the same cycle.
  - After DLY cycles: man_err=1, man_rdt=0.
  - Repeat with siz=3 on DBW=32: same response.
- Issue 2 reads with DLY=2, then assert rst_n=0 for 1 cycle before the responses are due.
  - Expect man_rdt=0 and man_err=0 immediately and afterwards; no stale responses.
- Macro defined. Read adr=1, siz=0, sub_rdt=0x0000_8000, uns=0.
  - Expect man_rdt=0xFFFF_FF80.
  - With uns=1: expect 0x0000_0080.

Source files
------------

// File: rtl/tcb_lib_processor2memory.sv
// rtl/tcb_lib_processor2memory.sv - processor-mode to memory-mode TCB converter
// Optional signed loads: define TCB_LIB_P2M_SIGN_EXT_EN to add man_uns.

package tcb_lib_p2m_pkg;
    typedef enum logic {
        TCB_LITTLE = 1'b0,
        TCB_BIG    = 1'b1
    } tcb_mode_endianness_t;
    typedef logic [2:0] tcb_size_t;
endpackage

module tcb_lib_processor2memory
    import tcb_lib_p2m_pkg::*;
#(
    parameter int                   ABW    = 32,
    parameter int                   DBW    = 32,
    parameter int                   DLY    = 1,
    parameter tcb_mode_endianness_t ENDIAN = TCB_LITTLE
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             man_vld,
    output logic             man_rdy,
    input  logic             man_wen,
    input  logic [ABW-1:0]   man_adr,
    input  tcb_size_t        man_siz,
    input  logic [DBW-1:0]   man_wdt,
`ifdef TCB_LIB_P2M_SIGN_EXT_EN
    input  logic             man_uns,
`endif
    output logic [DBW-1:0]   man_rdt,
    output logic             man_err,
    output logic             sub_vld,
    input  logic             sub_rdy,
    output logic             sub_wen,
    output logic [ABW-1:0]   sub_adr,
    output logic [DBW/8-1:0] sub_ben,
    output logic [DBW-1:0]   sub_wdt,
    input  logic [DBW-1:0]   sub_rdt,
    input  logic             sub_err
);

    localparam int BEN     = DBW / 8;
    localparam int LOG_BEN = $clog2(BEN);
    localparam int OFW     = (LOG_BEN > 0) ? LOG_BEN : 1;

    typedef struct packed {
        logic           act;
        logic           wen;
        logic [OFW-1:0] off;
        tcb_size_t      siz;
        logic           ill;
        logic           uns;
    } rsp_stage_t;

    logic [OFW-1:0] req_off;
    logic [OFW-1:0] req_mask;
    logic           req_ill;
    logic           req_uns;
    logic           transfer;
    int             req_n;
    int             req_idx;
    int             req_src;

    rsp_stage_t     stage_d [DLY];
    rsp_stage_t     stage_q [DLY];
    rsp_stage_t     rsp_last;
    logic [DBW-1:0] rsp_val;
    logic           rsp_sign;
    int             rsp_n;
    int             rsp_lane;

    if (LOG_BEN > 0) begin : g_off
        assign req_off = man_adr[OFW-1:0];
    end else begin : g_off_none
        assign req_off = '0;
    end

    // Without the signed-load option every read behaves as unsigned.
`ifdef TCB_LIB_P2M_SIGN_EXT_EN
    assign req_uns = man_uns;
`else
    assign req_uns = 1'b1;
`endif

    always_comb begin
        req_mask = '0;
        for (int b = 0; b < OFW; b++) begin
            req_mask[b] = (b < int'(man_siz));
        end
        req_ill = (int'(man_siz) > LOG_BEN) || ((req_off & req_mask) != '0);
    end

    assign sub_wen  = man_wen;
    assign sub_adr  = man_adr;
    assign sub_vld  = man_vld && !req_ill;
    assign man_rdy  = req_ill ? 1'b1 : sub_rdy;
    assign transfer = man_vld && man_rdy;

    always_comb begin
        req_n   = 32'd1 << man_siz;
        req_idx = 0;
        req_src = 0;
        sub_ben = '0;
        sub_wdt = '0;
        if (!req_ill) begin
            for (int l = 0; l < BEN; l++) begin
                req_idx = l - int'(req_off);
                if (req_idx >= 0 && req_idx < req_n) begin
                    req_src    = (ENDIAN == TCB_BIG) ? req_n - 1 - req_idx : req_idx;
                    sub_ben[l] = 1'b1;
                    sub_wdt[8*l +: 8] = man_wdt[8*req_src +: 8];
                end
            end
        end
    end

    always_comb begin
        stage_d[0].act = transfer;
        stage_d[0].wen = man_wen;
        stage_d[0].off = req_off;
        stage_d[0].siz = man_siz;
        stage_d[0].ill = req_ill;
        stage_d[0].uns = req_uns;
        for (int k = 1; k < DLY; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DLY; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DLY; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign rsp_last = stage_q[DLY-1];

    // Realign the returned lanes back to LSB, then fill the upper bytes.
    always_comb begin
        rsp_n    = 32'd1 << rsp_last.siz;
        rsp_lane = 0;
        rsp_val  = '0;
        rsp_sign = 1'b0;
        man_rdt  = '0;
        man_err  = 1'b0;
        if (rsp_last.act) begin
            man_err = rsp_last.ill | sub_err;
            if (!rsp_last.ill && !rsp_last.wen) begin
                for (int i = 0; i < BEN; i++) begin
                    if (i < rsp_n) begin
                        rsp_lane = (ENDIAN == TCB_BIG) ? int'(rsp_last.off) + rsp_n - 1 - i
                                                       : int'(rsp_last.off) + i;
                        rsp_val[8*i +: 8] = sub_rdt[8*rsp_lane +: 8];
                    end
                end
                rsp_sign = !rsp_last.uns && rsp_val[8*rsp_n-1];
                for (int i = 0; i < BEN; i++) begin
                    if (i >= rsp_n) begin
                        rsp_val[8*i +: 8] = {8{rsp_sign}};
                    end
                end
                man_rdt = rsp_val;
            end
        end
    end

endmodule

// File: tb/tb_tcb_lib_processor2memory.sv
// tb/tb_tcb_lib_processor2memory.sv - bench for three converter instances sharing one stimulus
// Instance g: DBW=32, DLY=g+1, big-endian for g==1; optional TCB_LIB_P2M_SIGN_EXT_EN.

module tb_tcb_lib_processor2memory;
    import tcb_lib_p2m_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        man_vld = 1'b0;
    logic        man_wen = 1'b0;
    logic [31:0] man_adr = '0;
    logic [2:0]  man_siz = '0;
    logic [31:0] man_wdt = '0;
`ifdef TCB_LIB_P2M_SIGN_EXT_EN
    logic        man_uns = 1'b0;
`endif
    logic        sub_rdy = 1'b0;
    logic [31:0] sub_rdt = '0;
    logic        sub_err = 1'b0;

    logic        o_rdy [3];
    logic [31:0] o_rdt [3];
    logic        o_err [3];
    logic        o_vld [3];
    logic        o_wen [3];
    logic [31:0] o_adr [3];
    logic [3:0]  o_ben [3];
    logic [31:0] o_wdt [3];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit act;
        bit wen;
        int off;
        int siz;
        bit ill;
        bit uns;
    } rec_t;
    rec_t hist [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tcb_lib_processor2memory #(
            .ABW    (32),
            .DBW    (32),
            .DLY    (g + 1),
            .ENDIAN (tcb_mode_endianness_t'(g == 1))
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .man_vld (man_vld),
            .man_rdy (o_rdy[g]),
            .man_wen (man_wen),
            .man_adr (man_adr),
            .man_siz (man_siz),
            .man_wdt (man_wdt),
`ifdef TCB_LIB_P2M_SIGN_EXT_EN
            .man_uns (man_uns),
`endif
            .man_rdt (o_rdt[g]),
            .man_err (o_err[g]),
            .sub_vld (o_vld[g]),
            .sub_rdy (sub_rdy),
            .sub_wen (o_wen[g]),
            .sub_adr (o_adr[g]),
            .sub_ben (o_ben[g]),
            .sub_wdt (o_wdt[g]),
            .sub_rdt (sub_rdt),
            .sub_err (sub_err)
        );
    end

    task automatic drive_req(input logic vld, input logic wen, input logic [31:0] adr,
                             input logic [2:0] siz, input logic [31:0] wdt);
        man_vld = vld;
        man_wen = wen;
        man_adr = adr;
        man_siz = siz;
        man_wdt = wdt;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_req(input bit big, input logic [31:0] adr, input logic [2:0] siz,
                                      input logic [31:0] wdt, output bit ill,
                                      output logic [3:0] ben, output logic [31:0] lanes);
        int n   = 1 << siz;
        int off = int'(adr % 4);
        ill   = (n > 4) || (off % n != 0);
        ben   = '0;
        lanes = '0;
        if (!ill) begin
            for (int i = 0; i < n; i++) begin
                ben[off+i] = 1'b1;
                lanes[8*(off+i) +: 8] = big ? wdt[8*(n-1-i) +: 8] : wdt[8*i +: 8];
            end
        end
    endfunction

    function automatic void model_rsp(input bit big, input rec_t r, input logic [31:0] rdt,
                                      input logic serr, output logic [31:0] erdt, output logic eerr);
        int n = 1 << r.siz;
        erdt = '0;
        eerr = 1'b0;
        if (r.act) begin
            eerr = r.ill || serr;
            if (!r.ill && !r.wen) begin
                for (int i = 0; i < n; i++) begin
                    erdt[8*i +: 8] = big ? rdt[8*(r.off+n-1-i) +: 8] : rdt[8*(r.off+i) +: 8];
                end
                if (!r.uns && erdt[8*n-1]) begin
                    for (int i = n; i < 4; i++) erdt[8*i +: 8] = 8'hFF;
                end
            end
        end
    endfunction

    task automatic test_reset();
        drive_req(1'b1, 1'b0, 32'h0000_0000, 3'd2, 32'h1234_5678);
        sub_rdy = 1'b1;
        sub_rdt = 32'hDEAD_BEEF;
        sub_err = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if ({o_rdt[g], o_err[g]} !== 33'h0) begin
                n_fail++;
                $display("FAIL reset_rsp[%0d]: got rdt=%h err=%b, want rdt=0 err=0", g, o_rdt[g], o_err[g]);
            end
            n_checks++;
            if ({o_vld[g], o_adr[g]} !== {1'b1, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_comb[%0d]: got vld=%b adr=%h, want vld=1 adr=0", g, o_vld[g], o_adr[g]);
            end
        end
        drive_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        sub_err = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_write_le();
        next_cycle();
        drive_req(1'b1, 1'b1, 32'h6, 3'd1, 32'h0000_BEEF);
        sub_rdy = 1'b1;
        sub_rdt = 32'hA5A5_A5A5;
        sub_err = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_vld[0], o_ben[0], o_wdt[0]} !== {1'b1, 4'b1100, 32'hBEEF_0000}) begin
            n_fail++;
            $display("FAIL write_le_req: got vld=%b ben=%b wdt=%h, want 1 1100 beef0000", o_vld[0], o_ben[0], o_wdt[0]);
        end
        next_cycle();
        drive_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({o_rdt[0], o_err[0]} !== 33'h0) begin
            n_fail++;
            $display("FAIL write_le_rsp: got rdt=%h err=%b, want 0 0", o_rdt[0], o_err[0]);
        end
    endtask

    task automatic test_read_be();
        next_cycle();
        drive_req(1'b1, 1'b0, 32'h4, 3'd2, 32'h0);
        sub_rdy = 1'b1;
        sub_rdt = 32'h1122_3344;
        @(negedge clk);
        n_checks++;
        if (o_ben[1] !== 4'b1111) begin
            n_fail++;
            $display("FAIL read_be_ben: got %b want 1111", o_ben[1]);
        end
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            drive_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
            @(negedge clk);
            n_checks++;
            if (o_rdt[1] !== ((c == 2) ? 32'h4433_2211 : 32'h0) || o_err[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL read_be_rsp c=%0d: got rdt=%h err=%b", c, o_rdt[1], o_err[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_b2b [4];
        exp_b2b = '{32'hAA, 32'hBB, 32'hCC, 32'hDD};
        sub_rdt = 32'hDDCC_BBAA;
        sub_rdy = 1'b1;
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            if (c < 4) drive_req(1'b1, 1'b0, 32'(c), 3'd0, 32'h0);
            else       drive_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
            @(negedge clk);
            if (c >= 3) begin
                n_checks++;
                if (o_rdt[2] !== exp_b2b[c-3]) begin
                    n_fail++;
                    $display("FAIL back_to_back c=%0d: got %h want %h", c, o_rdt[2], exp_b2b[c-3]);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        for (int s = 2; s <= 3; s++) begin
            next_cycle();
            drive_req(1'b1, 1'b0, 32'h3, 3'(s), 32'h0);
            sub_rdy = 1'b0;
            sub_rdt = 32'hFFFF_FFFF;
            sub_err = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({o_vld[0], o_rdy[0]} !== 2'b01) begin
                n_fail++;
                $display("FAIL misaligned_req siz=%0d: got vld=%b rdy=%b want 0 1", s, o_vld[0], o_rdy[0]);
            end
            next_cycle();
            drive_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
            @(negedge clk);
            n_checks++;
            if ({o_err[0], o_rdt[0]} !== {1'b1, 32'h0}) begin
                n_fail++;
                $display("FAIL misaligned_rsp siz=%0d: got err=%b rdt=%h want 1 0", s, o_err[0], o_rdt[0]);
            end
        end
        sub_rdy = 1'b1;
    endtask

    task automatic test_reset_midflight();
        sub_rdy = 1'b1;
        sub_rdt = 32'hCAFE_F00D;
        sub_err = 1'b1;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            drive_req(1'b1, 1'b0, 32'(4 * c), 3'd2, 32'h0);
            @(negedge clk);
        end
        drive_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        rst_n = 1'b0;
        #1;
        for (int g = 1; g < 3; g++) begin
            n_checks++;
            if ({o_rdt[g], o_err[g]} !== 33'h0) begin
                n_fail++;
                $display("FAIL reset_mid_now[%0d]: got rdt=%h err=%b want 0 0", g, o_rdt[g], o_err[g]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int g = 1; g < 3; g++) begin
                n_checks++;
                if ({o_rdt[g], o_err[g]} !== 33'h0) begin
                    n_fail++;
                    $display("FAIL reset_mid_after[%0d] c=%0d: got rdt=%h err=%b want 0 0", g, c, o_rdt[g], o_err[g]);
                end
            end
        end
        sub_err = 1'b0;
    endtask

`ifdef TCB_LIB_P2M_SIGN_EXT_EN
    task automatic test_sign_ext();
        logic [31:0] want;
        for (int u = 0; u < 2; u++) begin
            next_cycle();
            drive_req(1'b1, 1'b0, 32'h1, 3'd0, 32'h0);
            man_uns = u[0];
            sub_rdy = 1'b1;
            next_cycle();
            drive_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
            man_uns = 1'b0;
            sub_rdt = 32'h0000_8000;
            @(negedge clk);
            want = (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
            n_checks++;
            if (o_rdt[0] !== want) begin
                n_fail++;
                $display("FAIL sign_ext uns=%0d: got %h want %h", u, o_rdt[0], want);
            end
        end
    endtask
`endif

    task automatic test_random();
        bit          ill;
        logic [3:0]  eben;
        logic [31:0] ewdt;
        logic [31:0] erdt;
        logic        eerr;
        logic        erdy;
        rec_t        r;
        drive_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        repeat (3) next_cycle();
        hist.delete();
        for (int k = 0; k < 3; k++) hist.push_back('{default: 0});
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            drive_req(($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                      3'($urandom_range(0, 4)), $urandom);
`ifdef TCB_LIB_P2M_SIGN_EXT_EN
            man_uns = 1'($urandom);
`endif
            sub_rdy = 1'($urandom);
            sub_rdt = $urandom;
            sub_err = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                model_req(g == 1, man_adr, man_siz, man_wdt, ill, eben, ewdt);
                erdy = ill ? 1'b1 : sub_rdy;
                n_checks++;
                if ({o_vld[g], o_rdy[g], o_wen[g], o_adr[g], o_ben[g], o_wdt[g]} !==
                    {man_vld && !ill, erdy, man_wen, man_adr, eben, ewdt}) begin
                    n_fail++;
                    $display("FAIL rand_req[%0d] c=%0d: got vld=%b rdy=%b ben=%b wdt=%h, want %b %b %b %h",
                             g, c, o_vld[g], o_rdy[g], o_ben[g], o_wdt[g], man_vld && !ill, erdy, eben, ewdt);
                end
            end
            model_req(1'b0, man_adr, man_siz, man_wdt, ill, eben, ewdt);
            r.act = man_vld && (ill || sub_rdy);
            r.wen = man_wen;
            r.off = int'(man_adr % 4);
            r.siz = int'(man_siz);
            r.ill = ill;
`ifdef TCB_LIB_P2M_SIGN_EXT_EN
            r.uns = man_uns;
`else
            r.uns = 1'b1;
`endif
            hist.push_back(r);
            for (int g = 0; g < 3; g++) begin
                model_rsp(g == 1, hist[hist.size() - 1 - (g + 1)], sub_rdt, sub_err, erdt, eerr);
                n_checks++;
                if ({o_rdt[g], o_err[g]} !== {erdt, eerr}) begin
                    n_fail++;
                    $display("FAIL rand_rsp[%0d] c=%0d: got rdt=%h err=%b, want rdt=%h err=%b",
                             g, c, o_rdt[g], o_err[g], erdt, eerr);
                end
            end
        end
        drive_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_write_le();
        test_read_be();
        test_back_to_back();
        test_misaligned();
        test_reset_midflight();
`ifdef TCB_LIB_P2M_SIGN_EXT_EN
        test_sign_ext();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
